neuron_mac_n: RTL

NEURON_MAC_N -- requirements
Module: neuron_mac_n

---
 rtl/neuron_mac_n.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/neuron_mac_n.sv
// neuron_mac_n: single fixed-point neuron. Sequentially multiplies N_INPUTS
// captured inputs by stored weights, accumulates onto a bias with saturation,
// and applies hard-sigmoid or ReLU before presenting a registered result.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   En             global enable; when low FSM and datapath hold
//   Run            start request, honoured only in IDLE
//   Mode           activation select captured at start (0 sigmoid, 1 ReLU)
//   X              packed signed inputs, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   W_wr/W_addr/W_data  weight (addr < N_INPUTS) or bias (addr == N_INPUTS) write
//   Y, Y_valid     registered result and its one-cycle update strobe
//   Busy           high whenever not IDLE
module neuron_mac_n #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 4,
  parameter int N_INPUTS   = 4,
  parameter int ACC_GUARD  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 En,
  input  logic                                 Run,
  input  logic                                 Mode,
  input  logic [N_INPUTS*DATA_WIDTH-1:0]       X,
  input  logic                                 W_wr,
  input  logic [$clog2(N_INPUTS+1)-1:0]        W_addr,
  input  logic signed [DATA_WIDTH-1:0]         W_data,
  output logic signed [DATA_WIDTH-1:0]         Y,
  output logic                                 Y_valid,
  output logic                                 Busy
);

  localparam int ACC_WIDTH = DATA_WIDTH + ACC_GUARD;
  localparam int AW        = $clog2(N_INPUTS + 1);
  localparam int IW        = $clog2(N_INPUTS);
  localparam int PW        = 2 * DATA_WIDTH;
  // Sum is one bit wider than either addend so overflow is detectable.
  localparam int SUMW      = ((PW > ACC_WIDTH) ? PW : ACC_WIDTH) + 1;
  localparam int ONE       = 2 ** FRAC_BITS;
  localparam int RELU_MAX  = 2 ** (DATA_WIDTH - 1) - 1;

  localparam logic signed [ACC_WIDTH:0]   HALF_S = (ACC_WIDTH+1)'(ONE / 2);
  localparam logic signed [ACC_WIDTH:0]   ONE_S  = (ACC_WIDTH+1)'(ONE);
  localparam logic signed [ACC_WIDTH-1:0] RELU_S = ACC_WIDTH'(RELU_MAX);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    MAC    = 3'd2,
    ACT    = 3'd3,
    RESULT = 3'd4
  } state_t;

  state_t state, state_n;

  logic signed [DATA_WIDTH-1:0] w    [N_INPUTS];
  logic signed [DATA_WIDTH-1:0] xr   [N_INPUTS];
  logic signed [DATA_WIDTH-1:0] bias;
  logic signed [DATA_WIDTH-1:0] yb;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic [IW-1:0]                idx;
  logic                         mode_r;

  logic signed [PW-1:0]         prod;
  logic signed [PW-1:0]         prod_sh;
  logic signed [SUMW-1:0]       sum;
  logic signed [ACC_WIDTH-1:0]  acc_sat;
  logic signed [ACC_WIDTH:0]    acc_x;
  logic signed [ACC_WIDTH:0]    sig_t;
  logic signed [DATA_WIDTH-1:0] act_y;

  assign Busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  state <= IDLE;
    else if (En) state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (Run) state_n = LOAD;
      LOAD:    state_n = MAC;
      MAC:     if (idx == IW'(N_INPUTS - 1)) state_n = ACT;
      ACT:     state_n = RESULT;
      RESULT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Multiply-accumulate with saturation: the sum is in range only when all
  // bits from ACC_WIDTH-1 upward agree with the sign.
  always_comb begin
    prod    = PW'(xr[idx]) * PW'(w[idx]);
    prod_sh = prod >>> FRAC_BITS;
    sum     = SUMW'(acc) + SUMW'(prod_sh);
    if (sum[SUMW-1:ACC_WIDTH-1] == '0 || sum[SUMW-1:ACC_WIDTH-1] == '1)
      acc_sat = sum[ACC_WIDTH-1:0];
    else if (sum[SUMW-1])
      acc_sat = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    else
      acc_sat = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  end

  always_comb begin
    acc_x = (ACC_WIDTH+1)'(acc);
    sig_t = HALF_S + (acc_x >>> 2);
    act_y = '0;
    if (mode_r) begin
      if (acc[ACC_WIDTH-1])  act_y = '0;
      else if (acc > RELU_S) act_y = DATA_WIDTH'(RELU_MAX);
      else                   act_y = acc[DATA_WIDTH-1:0];
    end else begin
      if (sig_t[ACC_WIDTH])  act_y = '0;
      else if (sig_t > ONE_S) act_y = DATA_WIDTH'(ONE);
      else                   act_y = sig_t[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_INPUTS; i++) begin
        w[i]  <= '0;
        xr[i] <= '0;
      end
      bias    <= '0;
      acc     <= '0;
      idx     <= '0;
      mode_r  <= 1'b0;
      yb      <= '0;
      Y       <= '0;
      Y_valid <= 1'b0;
    end else begin
      Y_valid <= 1'b0;
      if (En) begin
        case (state)
          IDLE: begin
            // A write on the Run edge lands before LOAD reads the registers.
            if (W_wr && W_addr < AW'(N_INPUTS))
              w[W_addr[IW-1:0]] <= W_data;
            else if (W_wr && W_addr == AW'(N_INPUTS))
              bias <= W_data;
          end
          LOAD: begin
            for (int unsigned i = 0; i < N_INPUTS; i++)
              xr[i] <= X[i*DATA_WIDTH +: DATA_WIDTH];
            mode_r <= Mode;
            acc    <= ACC_WIDTH'(bias);
            idx    <= '0;
          end
          MAC: begin
            acc <= acc_sat;
            idx <= idx + IW'(1);
          end
          ACT:    yb <= act_y;
          RESULT: begin
            Y       <= yb;
            Y_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
